// File: rtl/button_debouncer_pkg.sv
// Shared state encoding and default parameters for the stacker button debouncer.
package button_debouncer_pkg;

    localparam int DEF_NUM_BTN         = 2;
    localparam int DEF_STABLE_SAMPLES  = 3;
    localparam int DEF_CNT_W           = 2;
    localparam bit DEF_BTN_ACTIVE_HIGH = 1'b1;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_PEND   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_PEND = 2'd3
    } deb_state_t;

endpackage

// File: rtl/button_debouncer_if.sv
// Raw pins and cleaned button outputs bundled between the board side and the debouncer.
interface button_debouncer_if import button_debouncer_pkg::*; #(
    parameter int NUM_BTN = DEF_NUM_BTN
) ();

    logic               debounce_clock;
    logic [NUM_BTN-1:0] btn_raw;
    logic [NUM_BTN-1:0] btn_level;
    logic [NUM_BTN-1:0] btn_press;
    logic [NUM_BTN-1:0] btn_release;
    logic               sample_tick;

    modport master (
        output debounce_clock,
        output btn_raw,
        input  btn_level,
        input  btn_press,
        input  btn_release,
        input  sample_tick
    );

    modport slave (
        input  debounce_clock,
        input  btn_raw,
        output btn_level,
        output btn_press,
        output btn_release,
        output sample_tick
    );

endinterface

// File: rtl/button_debouncer_cell.sv
// One button: 2-flop synchroniser, polarity fix-up, debounce FSM with sample counter,
// and registered press/release pulses. Only advances on sample_tick cycles.
module debounce_cell import button_debouncer_pkg::*; #(
    parameter int STABLE_SAMPLES  = DEF_STABLE_SAMPLES,
    parameter int CNT_W           = DEF_CNT_W,
    parameter bit BTN_ACTIVE_HIGH = DEF_BTN_ACTIVE_HIGH
) (
    input  logic master_clock,
    input  logic reset,
    input  logic sample_tick,
    input  logic btn_raw,
    output logic btn_level,
    output logic btn_press,
    output logic btn_release
);

    localparam logic [CNT_W:0] STABLE_C = (CNT_W+1)'(STABLE_SAMPLES);
    localparam bit             SINGLE   = (STABLE_SAMPLES == 1);

    logic             raw_s1;
    logic             raw_s2;
    logic             sample;
    deb_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W:0]   cnt_inc;

    always_ff @(posedge master_clock) begin
        if (reset) begin
            raw_s1 <= 1'b0;
            raw_s2 <= 1'b0;
        end else begin
            raw_s1 <= btn_raw;
            raw_s2 <= raw_s1;
        end
    end

    assign sample  = BTN_ACTIVE_HIGH ? raw_s2 : ~raw_s2;
    assign cnt_inc = {1'b0, cnt} + {{CNT_W{1'b0}}, 1'b1};

    // Counter never passes STABLE_SAMPLES-1: reaching the threshold always leaves the pending state.
    always_ff @(posedge master_clock) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            btn_level   <= 1'b0;
            btn_press   <= 1'b0;
            btn_release <= 1'b0;
        end else begin
            btn_press   <= 1'b0;
            btn_release <= 1'b0;
            if (sample_tick) begin
                case (state)
                    IDLE: begin
                        if (sample) begin
                            if (SINGLE) begin
                                state     <= PRESSED;
                                cnt       <= '0;
                                btn_level <= 1'b1;
                                btn_press <= 1'b1;
                            end else begin
                                state <= PRESS_PEND;
                                cnt   <= CNT_W'(1);
                            end
                        end
                    end
                    PRESS_PEND: begin
                        if (!sample) begin
                            state <= IDLE;
                            cnt   <= '0;
                        end else if (cnt_inc >= STABLE_C) begin
                            state     <= PRESSED;
                            cnt       <= '0;
                            btn_level <= 1'b1;
                            btn_press <= 1'b1;
                        end else begin
                            cnt <= cnt_inc[CNT_W-1:0];
                        end
                    end
                    PRESSED: begin
                        if (!sample) begin
                            if (SINGLE) begin
                                state       <= IDLE;
                                cnt         <= '0;
                                btn_level   <= 1'b0;
                                btn_release <= 1'b1;
                            end else begin
                                state <= RELEASE_PEND;
                                cnt   <= CNT_W'(1);
                            end
                        end
                    end
                    RELEASE_PEND: begin
                        if (sample) begin
                            state <= PRESSED;
                            cnt   <= '0;
                        end else if (cnt_inc >= STABLE_C) begin
                            state       <= IDLE;
                            cnt         <= '0;
                            btn_level   <= 1'b0;
                            btn_release <= 1'b1;
                        end else begin
                            cnt <= cnt_inc[CNT_W-1:0];
                        end
                    end
                    default: begin
                        state     <= IDLE;
                        cnt       <= '0;
                        btn_level <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: rtl/button_debouncer.sv
// Debouncer top: turns the slow debounce_clock (treated as data) into a one-cycle
// sample_tick and fans it out to one debounce_cell per button.
module button_debouncer import button_debouncer_pkg::*; #(
    parameter int NUM_BTN         = DEF_NUM_BTN,
    parameter int STABLE_SAMPLES  = DEF_STABLE_SAMPLES,
    parameter int CNT_W           = DEF_CNT_W,
    parameter bit BTN_ACTIVE_HIGH = DEF_BTN_ACTIVE_HIGH
) (
    input logic               master_clock,
    input logic               reset,
    button_debouncer_if.slave bus
);

    logic               dc_s1;
    logic               dc_s2;
    logic               dc_s3;
    logic               tick;
    logic [NUM_BTN-1:0] level;
    logic [NUM_BTN-1:0] press;
    logic [NUM_BTN-1:0] release_p;

    // dc_s3 is only the edge-detect history; clearing it on reset lets an already-high clock tick once.
    always_ff @(posedge master_clock) begin
        if (reset) begin
            dc_s1 <= 1'b0;
            dc_s2 <= 1'b0;
            dc_s3 <= 1'b0;
        end else begin
            dc_s1 <= bus.debounce_clock;
            dc_s2 <= dc_s1;
            dc_s3 <= dc_s2;
        end
    end

    assign tick = dc_s2 & ~dc_s3;

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_cell
        debounce_cell #(
            .STABLE_SAMPLES (STABLE_SAMPLES),
            .CNT_W          (CNT_W),
            .BTN_ACTIVE_HIGH(BTN_ACTIVE_HIGH)
        ) u_cell (
            .master_clock(master_clock),
            .reset       (reset),
            .sample_tick (tick),
            .btn_raw     (bus.btn_raw[i]),
            .btn_level   (level[i]),
            .btn_press   (press[i]),
            .btn_release (release_p[i])
        );
    end

    assign bus.sample_tick = tick;
    assign bus.btn_level   = level;
    assign bus.btn_press   = press;
    assign bus.btn_release = release_p;

endmodule

// File: tb/tb_button_debouncer.sv
// Scoreboard bench: one active-high and one active-low debouncer, debounce_clock toggling
// every 4 master_clock cycles; expected pulses are queued and matched by a negedge monitor.
module tb_button_debouncer;

    typedef struct packed {
        logic [1:0]  press;
        logic [1:0]  rel;
        logic [63:0] t;
    } exp_t;

    logic        master_clock = 1'b0;
    logic        reset        = 1'b1;
    logic        dclk;
    int          vectors      = 0;
    int          miscompares  = 0;
    exp_t        q_h[$];
    exp_t        q_l[$];
    bit          tick_ok      = 1'b0;
    logic [63:0] last_tick    = '0;

    button_debouncer_if #(.NUM_BTN(2)) bus_h ();
    button_debouncer_if #(.NUM_BTN(2)) bus_l ();

    button_debouncer #(
        .NUM_BTN(2), .STABLE_SAMPLES(3), .CNT_W(2), .BTN_ACTIVE_HIGH(1'b1)
    ) dut_h (
        .master_clock(master_clock),
        .reset       (reset),
        .bus         (bus_h)
    );

    button_debouncer #(
        .NUM_BTN(2), .STABLE_SAMPLES(3), .CNT_W(2), .BTN_ACTIVE_HIGH(1'b0)
    ) dut_l (
        .master_clock(master_clock),
        .reset       (reset),
        .bus         (bus_l)
    );

    always #5 master_clock = ~master_clock;

    // Edges of dclk land 3 time units before a master_clock rising edge, never on one.
    initial begin
        dclk = 1'b0;
        #2;
        forever #40 dclk = ~dclk;
    end

    assign bus_h.debounce_clock = dclk;
    assign bus_l.debounce_clock = dclk;

    task automatic checkOutput(input string name, input logic [1:0] got, input logic [1:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %b, expected %b at %0t", name, got, exp, $time);
        end
    endtask

    task automatic waitFall();
        @(negedge dclk);
        #1;
    endtask

    task automatic applyStimulus(input logic [1:0] raw_h, input logic [1:0] raw_l, input int periods);
        bus_h.btn_raw = raw_h;
        bus_l.btn_raw = raw_l;
        repeat (periods) waitFall();
    endtask

    task automatic expectEvent(input int d, input logic [1:0] press, input logic [1:0] rel,
                               input logic [63:0] t);
        exp_t e;
        e.press = press;
        e.rel   = rel;
        e.t     = t;
        if (d == 0) q_h.push_back(e);
        else        q_l.push_back(e);
    endtask

    task automatic checkPulse(input int d, input logic [1:0] press, input logic [1:0] rel);
        exp_t  e;
        string nm;
        int    n;
        nm = (d == 0) ? "h" : "l";
        n  = (d == 0) ? q_h.size() : q_l.size();
        vectors++;
        if (n == 0) begin
            miscompares++;
            $display("[TB] FAIL unexpected_pulse_%s: press=%b release=%b at %0t, expected no pulse",
                     nm, press, rel, $time);
        end else begin
            if (d == 0) e = q_h.pop_front();
            else        e = q_l.pop_front();
            if (press !== e.press || rel !== e.rel || $time != e.t) begin
                miscompares++;
                $display("[TB] FAIL pulse_%s: press=%b release=%b at %0t, expected press=%b release=%b at %0t",
                         nm, press, rel, $time, e.press, e.rel, e.t);
            end
        end
    endtask

    // Monitor: every pulse must match the head of its queue; ticks must stay 8 cycles apart.
    always @(negedge master_clock) begin
        if (reset) begin
            tick_ok = 1'b0;
        end else begin
            if ((bus_h.btn_press | bus_h.btn_release) != 2'b00)
                checkPulse(0, bus_h.btn_press, bus_h.btn_release);
            if ((bus_l.btn_press | bus_l.btn_release) != 2'b00)
                checkPulse(1, bus_l.btn_press, bus_l.btn_release);
            if (bus_h.sample_tick === 1'b1) begin
                if (tick_ok) begin
                    vectors++;
                    if ($time - last_tick != 64'd80) begin
                        miscompares++;
                        $display("[TB] FAIL tick_period: got %0d, expected 80", $time - last_tick);
                    end
                end
                last_tick = $time;
                tick_ok   = 1'b1;
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    // A pulse for a level held from t0 appears at t0 + 227: third rising dclk edge
    // (t0+39+160) plus 2 sync cycles to the tick, 1 cycle to the pulse, sampled on the negedge.
    initial begin
        logic [63:0] t0;
        bus_h.btn_raw = 2'b00;
        bus_l.btn_raw = 2'b11;
        repeat (3) @(negedge master_clock);
        checkOutput("reset_level_h",   bus_h.btn_level,   2'b00);
        checkOutput("reset_press_h",   bus_h.btn_press,   2'b00);
        checkOutput("reset_release_h", bus_h.btn_release, 2'b00);
        checkOutput("reset_tick_h",    {1'b0, bus_h.sample_tick}, 2'b00);
        checkOutput("reset_level_l",   bus_l.btn_level,   2'b00);
        checkOutput("reset_press_l",   bus_l.btn_press,   2'b00);
        reset = 1'b0;

        repeat (50) @(negedge master_clock);
        checkOutput("idle_level_h", bus_h.btn_level, 2'b00);
        checkOutput("idle_level_l", bus_l.btn_level, 2'b00);
        waitFall();

        t0 = $time;
        expectEvent(0, 2'b01, 2'b00, t0 + 227);
        applyStimulus(2'b01, 2'b11, 4);
        checkOutput("press_level_h", bus_h.btn_level, 2'b01);

        applyStimulus(2'b00, 2'b11, 1);
        checkOutput("release_glitch_mid_h", bus_h.btn_level, 2'b01);
        applyStimulus(2'b01, 2'b11, 3);
        checkOutput("release_glitch_after_h", bus_h.btn_level, 2'b01);

        t0 = $time;
        expectEvent(0, 2'b00, 2'b01, t0 + 227);
        applyStimulus(2'b00, 2'b11, 4);
        checkOutput("release_level_h", bus_h.btn_level, 2'b00);

        applyStimulus(2'b01, 2'b11, 2);
        checkOutput("press_glitch_mid_h", bus_h.btn_level, 2'b00);
        applyStimulus(2'b00, 2'b11, 3);
        checkOutput("press_glitch_after_h", bus_h.btn_level, 2'b00);

        applyStimulus(2'b01, 2'b11, 2);
        t0 = $time;
        expectEvent(0, 2'b01, 2'b00, t0 + 227);
        reset = 1'b1;
        repeat (2) @(negedge master_clock);
        checkOutput("mid_reset_level_h", bus_h.btn_level, 2'b00);
        checkOutput("mid_reset_press_h", bus_h.btn_press, 2'b00);
        reset = 1'b0;
        applyStimulus(2'b01, 2'b11, 4);
        checkOutput("post_reset_level_h", bus_h.btn_level, 2'b01);

        t0 = $time;
        expectEvent(0, 2'b00, 2'b01, t0 + 227);
        applyStimulus(2'b00, 2'b11, 4);
        checkOutput("post_reset_release_h", bus_h.btn_level, 2'b00);

        t0 = $time;
        expectEvent(0, 2'b11, 2'b00, t0 + 227);
        expectEvent(1, 2'b11, 2'b00, t0 + 227);
        applyStimulus(2'b11, 2'b00, 4);
        checkOutput("both_press_level_h", bus_h.btn_level, 2'b11);
        checkOutput("both_press_level_l", bus_l.btn_level, 2'b11);

        t0 = $time;
        expectEvent(0, 2'b00, 2'b11, t0 + 227);
        expectEvent(1, 2'b00, 2'b11, t0 + 227);
        applyStimulus(2'b00, 2'b11, 4);
        checkOutput("both_release_level_h", bus_h.btn_level, 2'b00);
        checkOutput("both_release_level_l", bus_l.btn_level, 2'b00);

        t0 = $time;
        expectEvent(1, 2'b10, 2'b00, t0 + 227);
        applyStimulus(2'b00, 2'b01, 4);
        checkOutput("low_bit1_level_l", bus_l.btn_level, 2'b10);
        checkOutput("low_bit1_level_h", bus_h.btn_level, 2'b00);

        t0 = $time;
        expectEvent(1, 2'b00, 2'b10, t0 + 227);
        applyStimulus(2'b00, 2'b11, 4);
        checkOutput("low_bit1_release_l", bus_l.btn_level, 2'b00);

        applyStimulus(2'b00, 2'b11, 2);
        vectors++;
        if (q_h.size() != 0 || q_l.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL missing_pulses: %0d/%0d still queued, expected 0/0", q_h.size(), q_l.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
